bus_mem_slave: RTL

Parametrised behavioural memory slave for the `mips_cpu_bus` Avalon-style interface, used by CPU testbenches in place of hand-written per-test memory arrays. It maps one configurable byte-address window onto a word array and merges any byte-lane pattern on writes. It inserts fixed or pseudo-random wait states through `waitrequest`. It also flags illegal or out-of-window accesses and exposes a peek port for end-of-test checks.

---
 rtl/bus_mem_pkg.sv | 32 +++
 rtl/bus_mem_stall_gen.sv | 85 ++++++++
 rtl/bus_mem_slave.sv | 101 ++++++++++
 3 files changed

// File: rtl/bus_mem_pkg.sv
// Shared types, constants and helpers for the behavioural bus memory slave.
package bus_mem_pkg;

  // Stall sequencer states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_t;

  // Galois feedback mask for the 16-bit stall-length generator
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Replace the byte lanes selected by be, keep the others from old_word
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic [3:0]  be
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

  // One right-shift step of the Galois LFSR
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/bus_mem_stall_gen.sv
// Wait-state sequencer: decides how long each access stalls, drives
// waitrequest, and tells the memory when an access completes or is abandoned.
module bus_mem_stall_gen
  import bus_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 0,
  parameter int          STALL_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic waitrequest,
  output logic accept,
  output logic req_drop
);

  localparam logic [4:0] FIXED_N = 5'(WAIT_CYCLES);
  localparam logic [4:0] RAND_MOD = 5'(WAIT_CYCLES + 1);

  stall_state_t state_q;
  logic [3:0]   cnt_q;
  logic [15:0]  lfsr_q;
  logic [4:0]   n_stall;

  // Stall length for an access starting now: fixed, or LFSR-derived in random mode
  always_comb begin
    n_stall = FIXED_N;
    if (STALL_MODE != 0) n_stall = {1'b0, lfsr_q[3:0]} % RAND_MOD;
  end

  // Handshake outputs; everything is held quiet while reset is asserted
  always_comb begin
    waitrequest = 1'b0;
    accept      = 1'b0;
    req_drop    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          waitrequest = req && (n_stall != 5'd0);
          accept      = req && (n_stall == 5'd0);
        end
        STALL: begin
          waitrequest = (cnt_q != 4'd0);
          accept      = req && (cnt_q == 4'd0);
          req_drop    = !req;
        end
        default: ;
      endcase
    end
  end

  // Stall FSM, countdown and LFSR; a request dropped mid-stall returns to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (STALL_MODE != 0) lfsr_q <= lfsr_step(lfsr_q);
            if (n_stall != 5'd0) begin
              state_q <= STALL;
              cnt_q   <= 4'(n_stall - 5'd1);
            end
          end
        end
        STALL: begin
          if (!req) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_mem_slave.sv
// Behavioural memory slave for the mips_cpu_bus interface: one byte-address
// window mapped onto a word array, byte-lane writes, wait-state insertion,
// error flagging and a combinational peek port for end-of-test checks.
module bus_mem_slave
  import bus_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 0,
  parameter int          STALL_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              address,
  input  logic                     write,
  input  logic                     read,
  output logic                     waitrequest,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  output logic [31:0]              readdata,
  output logic                     bus_error,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [31:0]              dbg_data
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          in_window;
  logic          halt;
  logic          mem_hit;
  logic          access_err;
  logic          req;
  logic          accept;
  logic          req_drop;
  logic [31:0]   readdata_q;
  logic          bus_error_q;

  // Clear the array at time 0; reset never touches memory contents
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  end

  // Address decode; addresses below BASE_ADDR wrap to huge offsets and fall outside
  assign offset     = address - BASE_ADDR;
  assign in_window  = (offset < WIN_BYTES);
  assign word_idx   = offset[AW+1:2];
  assign halt       = (address == 32'h0);
  assign mem_hit    = in_window && !halt;
  assign req        = read || write;

  // Illegal when misaligned, outside the window (halt reads excepted),
  // a write to the halt address, or read and write raised together
  assign access_err = (address[1:0] != 2'b00)
                   || (!in_window && !halt)
                   || (write && halt)
                   || (write && read);

  bus_mem_stall_gen #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .STALL_MODE (STALL_MODE),
    .LFSR_SEED  (LFSR_SEED)
  ) u_stall (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .waitrequest(waitrequest),
    .accept     (accept),
    .req_drop   (req_drop)
  );

  // Byte-merged write on the completing edge; writes win over simultaneous reads
  always_ff @(posedge clk) begin
    if (accept && write && mem_hit) begin
      mem[word_idx] <= merge_bytes(mem[word_idx], writedata, byteenable);
    end
  end

  // Registered read data (held between reads) and one-cycle error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q  <= 32'h0;
      bus_error_q <= 1'b0;
    end else begin
      bus_error_q <= req_drop || (accept && access_err);
      if (accept && read && !write) begin
        readdata_q <= mem_hit ? mem[word_idx] : 32'h0;
      end
    end
  end

  assign readdata  = readdata_q;
  assign bus_error = bus_error_q;
  assign dbg_data  = mem[dbg_addr];

endmodule
